fp_add_issue: RTL and testbench
===============================

FP_ADD_ISSUE -- requirements
Module: fp_add_issue

Interface
REQ-001 Parameter DEPTH, default 4: operand-pair FIFO entries; power of two, 2..16.
REQ-002 Parameter HOLD_CYCLES, default 5: cycles add_a/add_b are held stable for the downstream adder, 1..15.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_a, in_b  input  32 each  IEEE-754 single operands.
REQ-007 in_ready  output  1  FIFO can accept a pair.
REQ-008 add_a, add_b  output  32 each  normalised operands to adder.
REQ-009 issue_valid  output  1  add_a/add_b valid and stable.
REQ-010 spec_valid  output  1  one-cycle pulse, special-case result ready.
REQ-011 spec_result  output  32  bypass result.
REQ-012 spec_flags  output  3  {nan, inf, ftz}.

Function
REQ-013 Push on in_valid && in_ready; in_ready = (count != DEPTH), from registered count; no write-through when full.
REQ-014 FSM states IDLE, CLASSIFY, ISSUE, SPECIAL; IDLE with FIFO non-empty pops the head into an operand register, next state CLASSIFY.
REQ-015 Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
REQ-016 CLASSIFY (1 cycle): denormal (exp 0, mant != 0) flushed to signed zero, ftz flag set; then special rules, else ISSUE.
REQ-017 Either NaN, or +inf plus -inf: spec_result 0x7FC00000, nan=1.
REQ-018 Otherwise either inf: spec_result is that inf (sign preserved), inf=1.
REQ-019 Otherwise either operand zero: spec_result is the other operand; both zero gives sign = sign_a AND sign_b.
REQ-020 SPECIAL lasts exactly 1 cycle with spec_valid=1, then IDLE.
REQ-021 ISSUE: add_a/add_b loaded on entry, issue_valid=1 for exactly HOLD_CYCLES consecutive cycles via a down-counter, then IDLE; operands never change while issue_valid=1.
REQ-022 Issue latency: pop-to-first issue_valid = 2 cycles from an empty-FIFO push (push, IDLE pop, CLASSIFY).
REQ-023 issue_valid and spec_valid are never simultaneously high.
REQ-024 add_a, add_b, spec_result, spec_flags hold their last values when their valid is low.

Reset
REQ-025 Reset flushes the FIFO (count 0, pointers 0), FSM to IDLE, counter 0.
REQ-026 Reset values: in_ready=1 on the first cycle after reset, all other outputs 0.
REQ-027 Reset mid-ISSUE or mid-SPECIAL aborts the operation; issue_valid and spec_valid are 0 on the next cycle.

Configuration
REQ-028 Macro FP_ISSUE_SWAP_EN defined: in ISSUE, add_a holds the operand of larger magnitude ({exp,mant} unsigned compare, ties keep order).
REQ-029 Macro FP_ISSUE_SWAP_EN undefined: add_a=in_a and add_b=in_b unswapped; all other behaviour identical.

Structure
REQ-030 Package fp_issue_pkg holds the state enum, QNAN constant 0x7FC00000, field-width localparams, and the flag struct/bit indices.
REQ-031 One sub-module fp_issue_fifo (synchronous FIFO, DEPTH parameter, count output); classification logic stays inline.

Verification
REQ-032 Push 0x3F800000 + 0x40000000, SWAP_EN on -> add_a=0x40000000, add_b=0x3F800000, issue_valid high 5 cycles starting 2 cycles after push.
REQ-033 Push 0x7F800000 + 0xFF800000 -> spec_valid pulse, spec_result 0x7FC00000, flags 3'b100.
REQ-034 Push 0x00000001 + 0xBF800000 -> spec_result 0xBF800000, flags 3'b001, no issue_valid.
REQ-035 Push 6 non-special pairs back-to-back -> FIFO fills, in_ready drops per REQ-013, no pair lost, issue windows strictly sequential in order.
REQ-036 Assert reset on 3rd cycle of an ISSUE with 2 pairs queued -> next cycle issue_valid=0, in_ready=1, no further issues.

Source files
------------

// File: rtl/fp_issue_pkg.sv
// Shared types and constants for the fp_add_issue operand-staging block.
// The FP_ISSUE_SWAP_EN macro is consumed by fp_add_issue, not here.
package fp_issue_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int FLAG_NAN = 2;
  localparam int FLAG_INF = 1;
  localparam int FLAG_FTZ = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    ISSUE    = 2'd2,
    SPECIAL  = 2'd3
  } state_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic ftz;
  } flags_t;

  function automatic logic is_denorm(input logic [FP_W-1:0] v);
    return (v[FP_W-2 -: EXP_W] == '0) && (v[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_issue_fifo.sv
// Synchronous operand-pair FIFO; DEPTH must be a power of two so pointers wrap naturally.
module fp_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Guarded here as well so a careless caller cannot overrun or underrun.
  assign do_push = push_i && (count_q != FULL);
  assign do_pop  = pop_i  && (count_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fp_add_issue.sv
// Stages IEEE-754 operand pairs, bypasses special cases, and holds normal pairs for the adder.
// Define FP_ISSUE_SWAP_EN to present the larger-magnitude operand on add_a.
module fp_add_issue
  import fp_issue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        issue_valid,
  output logic        spec_valid,
  output logic [31:0] spec_result,
  output logic [2:0]  spec_flags,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e      state_q;
  logic [31:0] op_a_q, op_b_q, add_a_q, add_b_q, spec_result_q;
  logic [3:0]  hold_q;
  logic        issue_valid_q, spec_valid_q;
  flags_t      spec_flags_q;

  logic [63:0] head;
  logic [AW:0] count;
  logic        pop;

  // A pair transfers when in_valid && in_ready at a rising edge; in_ready
  // depends only on the registered count, never on in_valid.
  assign in_ready = (count != FULL);
  assign pop      = (state_q == IDLE) && (count != '0);

  fp_issue_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid && in_ready),
    .pop_i   (pop),
    .wdata_i ({in_a, in_b}),
    .rdata_o (head),
    .count_o (count)
  );

  logic [31:0] fa, fb, spec_res_d, issue_a_d, issue_b_d;
  flags_t      flags_d;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special, swap;

  always_comb begin
    fa = is_denorm(op_a_q) ? {op_a_q[31], 31'b0} : op_a_q;
    fb = is_denorm(op_b_q) ? {op_b_q[31], 31'b0} : op_b_q;
    a_nan  = (fa[30:23] == EXP_MAX) && (fa[22:0] != '0);
    b_nan  = (fb[30:23] == EXP_MAX) && (fb[22:0] != '0);
    a_inf  = (fa[30:23] == EXP_MAX) && (fa[22:0] == '0);
    b_inf  = (fb[30:23] == EXP_MAX) && (fb[22:0] == '0);
    a_zero = (fa[30:0] == '0);
    b_zero = (fb[30:0] == '0);
    flags_d     = '0;
    flags_d.ftz = is_denorm(op_a_q) || is_denorm(op_b_q);
    spec_res_d  = '0;
    is_special  = 1'b1;
    if (a_nan || b_nan || (a_inf && b_inf && (fa[31] != fb[31]))) begin
      spec_res_d  = QNAN;
      flags_d.nan = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res_d  = a_inf ? fa : fb;
      flags_d.inf = 1'b1;
    end else if (a_zero && b_zero) begin
      spec_res_d = {fa[31] & fb[31], 31'b0};
    end else if (a_zero || b_zero) begin
      spec_res_d = a_zero ? fb : fa;
    end else begin
      is_special = 1'b0;
    end
`ifdef FP_ISSUE_SWAP_EN
    swap = (fa[30:0] < fb[30:0]);
`else
    swap = 1'b0;
`endif
    issue_a_d = swap ? fb : fa;
    issue_b_d = swap ? fa : fb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      hold_q        <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      issue_valid_q <= 1'b0;
      spec_valid_q  <= 1'b0;
      spec_result_q <= '0;
      spec_flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          op_a_q  <= head[63:32];
          op_b_q  <= head[31:0];
          state_q <= CLASSIFY;
        end
        CLASSIFY: if (is_special) begin
          spec_valid_q  <= 1'b1;
          spec_result_q <= spec_res_d;
          spec_flags_q  <= flags_d;
          state_q       <= SPECIAL;
        end else begin
          add_a_q       <= issue_a_d;
          add_b_q       <= issue_b_d;
          issue_valid_q <= 1'b1;
          hold_q        <= HOLD_LAST;
          state_q       <= ISSUE;
        end
        ISSUE: if (hold_q == '0) begin
          issue_valid_q <= 1'b0;
          state_q       <= IDLE;
        end else begin
          hold_q <= hold_q - 1'b1;
        end
        SPECIAL: begin
          spec_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign issue_valid = issue_valid_q;
  assign spec_valid  = spec_valid_q;
  assign spec_result = spec_result_q;
  assign spec_flags  = spec_flags_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fp_add_issue.sv
// Bench for fp_add_issue: directed and random operand pairs against a rule-level reference model.
module tb_fp_add_issue;

  localparam int DEPTH = 4;
  localparam int HOLD  = 5;
  localparam int W     = 68;  // {is_spec, a/result, b, flags}
  localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset, in_valid;
  logic [31:0] in_a, in_b;
  logic        in_ready, issue_valid, spec_valid;
  logic [31:0] add_a, add_b, spec_result;
  logic [2:0]  spec_flags;
  logic [1:0]  state_dbg;

  fp_add_issue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_ready    (in_ready),
    .add_a       (add_a),
    .add_b       (add_b),
    .issue_valid (issue_valid),
    .spec_valid  (spec_valid),
    .spec_result (spec_result),
    .spec_flags  (spec_flags),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // 0 = zero (denormals count as zero), 1 = finite, 2 = infinity, 3 = NaN
  function automatic int cls(input logic [31:0] v);
    if (v[30:23] == 8'hFF) return (v[22:0] == 0) ? 2 : 3;
    if (v[30:23] == 8'h00) return 0;
    return 1;
  endfunction

  function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b);
    logic ftz;
    int ca, cb;
    ftz = (a[30:23] == 0 && a[22:0] != 0) || (b[30:23] == 0 && b[22:0] != 0);
    ca = cls(a);
    cb = cls(b);
    if (ca == 0) a = {a[31], 31'b0};
    if (cb == 0) b = {b[31], 31'b0};
    if (ca == 3 || cb == 3 || (ca == 2 && cb == 2 && a[31] != b[31]))
      return {1'b1, QNAN_C, 32'b0, 1'b1, 1'b0, ftz};
    if (ca == 2) return {1'b1, a, 32'b0, 1'b0, 1'b1, ftz};
    if (cb == 2) return {1'b1, b, 32'b0, 1'b0, 1'b1, ftz};
    if (ca == 0 && cb == 0) return {1'b1, a[31] & b[31], 31'b0, 32'b0, 2'b00, ftz};
    if (ca == 0) return {1'b1, b, 32'b0, 2'b00, ftz};
    if (cb == 0) return {1'b1, a, 32'b0, 2'b00, ftz};
`ifdef FP_ISSUE_SWAP_EN
    if (b[30:0] > a[30:0]) return {1'b0, b, a, 3'b000};
`endif
    return {1'b0, a, b, 3'b000};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:0] = '0;
      1: begin v[30:23] = 8'h00; v[0] = 1'b1; end
      2: v[30:0] = {8'hFF, 23'h0};
      3: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      default: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h7F;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
      stalls++;
    end
    check("push_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || state_dbg != 2'd0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic         prev_iv = 1'b0, prev_sv = 1'b0;
  int           run_len = 0;
  logic [31:0]  last_a = '0, last_b = '0, last_r = '0;
  logic [2:0]   last_f = '0;
  logic [W-1:0] win;

  always @(negedge clk) begin
    if (reset) begin
      prev_iv = 1'b0; prev_sv = 1'b0; run_len = 0;
      last_a = '0; last_b = '0; last_r = '0; last_f = '0;
    end else begin
      check("valid_exclusive", {31'b0, issue_valid & spec_valid}, 32'd0);
      if (issue_valid) begin
        if (!prev_iv) begin
          check("issue_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          win = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          check("issue_kind", {31'b0, win[67]}, 32'd0);
          last_a = win[66:35];
          last_b = win[34:3];
          run_len = 1;
        end else begin
          run_len++;
        end
        check("add_a", add_a, last_a);
        check("add_b", add_b, last_b);
      end else begin
        if (prev_iv) check("hold_len", run_len, HOLD);
        check("add_a_hold", add_a, last_a);
        check("add_b_hold", add_b, last_b);
      end
      if (spec_valid) begin
        check("spec_pulse", {31'b0, prev_sv}, 32'd0);
        check("spec_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        win = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("spec_kind", {31'b0, win[67]}, 32'd1);
        last_r = win[66:35];
        last_f = win[2:0];
      end
      check("spec_result", spec_result, last_r);
      check("spec_flags", {29'b0, spec_flags}, {29'b0, last_f});
      prev_iv = issue_valid;
      prev_sv = spec_valid;
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int k;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    idle(3);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
    check("rst_spec_valid", {31'b0, spec_valid}, 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    check("rst_spec_result", spec_result, 32'd0);
    check("rst_spec_flags", {29'b0, spec_flags}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Latency: issue_valid seen at the third negedge after the push edge.
    push(32'h3F80_0000, 32'h4000_0000);
    k = 0;
    while (!issue_valid && k < 20) begin @(negedge clk); k++; end
    check("issue_latency", k, 32'd3);
    @(posedge clk); #1;
    drain();

    push(32'h7F80_0000, 32'hFF80_0000);  // +inf + -inf
    drain();
    push(32'h0000_0001, 32'hBF80_0000);  // denormal flushed
    drain();
    push(32'h4040_0000, 32'hC040_0000);  // equal magnitude
    push(32'h0000_0000, 32'h8000_0000);
    push(32'h8000_0000, 32'h8000_0000);
    push(32'h7FC0_1234, 32'h3F80_0000);
    push(32'hFF80_0000, 32'h4000_0000);
    push(32'h8000_0001, 32'h8000_0000);
    drain();

    // Back-to-back normal pairs must overflow DEPTH and stall the producer.
    stalls = 0;
    for (int i = 0; i < 6; i++) push(32'h3F80_0000 + (i << 20), 32'h4100_0000 - (i << 18));
    check("fifo_stalled", {31'b0, stalls > 0}, 32'd1);
    drain();
    check("ready_after_drain", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 40; i++) begin
      push(rand_op(), rand_op());
      idle($urandom_range(0, 6));
    end
    drain();

    // Abort in the third ISSUE cycle with two pairs still queued.
    push(32'h3F80_0000, 32'h4000_0000);
    push(32'h4040_0000, 32'h4080_0000);
    push(32'h40A0_0000, 32'h40C0_0000);
    check("abort_setup", {31'b0, issue_valid}, 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("abort_issue_valid", {31'b0, issue_valid}, 32'd0);
    check("abort_spec_valid", {31'b0, spec_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(40);
    check("abort_no_issue", {31'b0, issue_valid}, 32'd0);
    check("abort_idle_state", {30'b0, state_dbg}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
